// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: 32-bit fetches and 1/2/4-byte loads/stores onto a byte-wide RAM/IO bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; fixed load/store priority otherwise.
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              inst_IF_req,
  input  logic [ADDR_W-1:0] inst_IF_addr,
  output logic              inst_IF_flag,
  output logic [31:0]       inst_IF,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_flag,
  output logic [31:0]       data_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic              is_fetch;
  logic              paused;
  logic              wr_en;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0][7:0]   rbuf;
`ifdef MEM_ARB_RR_EN
  logic              last_data;
`endif

  logic              fetch_ok;
  logic              pick_d;
  logic              grant;
  logic [2:0]        size_n;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        wr_byte;
  logic              io_stall;
  logic [31:0]       rd_word;

  assign mem_wr   = wr_en & rdy;
  assign fetch_ok = inst_IF_req & ~flush;

`ifdef MEM_ARB_RR_EN
  assign pick_d = data_req & (~fetch_ok | ~last_data);
`else
  assign pick_d = data_req;
`endif

  assign grant = (state == S_IDLE) & ~inst_IF_flag & ~data_flag & (data_req | fetch_ok);

  always_comb begin
    size_n = 3'd4;
    if (pick_d) begin
      case (data_size)
        2'b00:   size_n = 3'd1;
        2'b01:   size_n = 3'd2;
        default: size_n = 3'd4;
      endcase
    end
  end

  assign cur_addr = (state == S_IDLE) ? (pick_d ? data_addr : inst_IF_addr)
                                      : addr_q + {{(ADDR_W-3){1'b0}}, cnt};
  assign wr_byte  = (state == S_IDLE) ? data_wdata[7:0] : wdata_q[{cnt[1:0], 3'b000} +: 8];
  assign io_stall = (cur_addr[17:16] == IO_SEL) & io_buffer_full;

  // The final byte arrives on mem_din in the completion cycle, so it bypasses rbuf.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes)
        rd_word[8*i +: 8] = (3'(i) == nbytes - 3'd1) ? mem_din : rbuf[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      nbytes       <= '0;
      is_fetch     <= 1'b0;
      paused       <= 1'b0;
      wr_en        <= 1'b0;
      mem_a        <= '0;
      mem_dout     <= '0;
      inst_IF_flag <= 1'b0;
      inst_IF      <= '0;
      data_flag    <= 1'b0;
      data_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
      last_data    <= 1'b0;
`endif
    end else begin
      inst_IF_flag <= 1'b0;
      data_flag    <= 1'b0;
      if (!rdy) begin
        // RAM data in flight is lost during a pause, so a read must restart.
        if (state == S_RD) paused <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (grant) begin
              is_fetch <= ~pick_d;
              nbytes   <= size_n;
              paused   <= 1'b0;
`ifdef MEM_ARB_RR_EN
              last_data <= pick_d;
`endif
              if (pick_d && data_wr) begin
                state <= S_WR;
                if (io_stall) begin
                  wr_en <= 1'b0;
                  cnt   <= 3'd0;
                end else begin
                  mem_a    <= cur_addr;
                  mem_dout <= wr_byte;
                  wr_en    <= 1'b1;
                  cnt      <= 3'd1;
                end
              end else begin
                state <= S_RD;
                mem_a <= cur_addr;
                wr_en <= 1'b0;
                cnt   <= 3'd1;
              end
            end
          end
          S_RD: begin
            if (is_fetch && flush) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else if (paused) begin
              mem_a  <= addr_q;
              cnt    <= 3'd1;
              paused <= 1'b0;
            end else begin
              if (cnt < nbytes) mem_a <= cur_addr;
              if (cnt == nbytes + 3'd1) begin
                state <= S_IDLE;
                cnt   <= '0;
                if (is_fetch) begin
                  inst_IF_flag <= 1'b1;
                  inst_IF      <= rd_word;
                end else begin
                  data_flag  <= 1'b1;
                  data_rdata <= rd_word;
                end
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          S_WR: begin
            if (cnt == nbytes) begin
              data_flag <= 1'b1;
              wr_en     <= 1'b0;
              state     <= S_IDLE;
              cnt       <= '0;
            end else if (io_stall) begin
              wr_en <= 1'b0;
            end else begin
              mem_a    <= cur_addr;
              mem_dout <= wr_byte;
              wr_en    <= 1'b1;
              cnt      <= cnt + 3'd1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
            wr_en <= 1'b0;
          end
        endcase
      end
    end
  end

  // Request latches and read-byte buffer carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (grant) begin
        addr_q  <= pick_d ? data_addr : inst_IF_addr;
        wdata_q <= data_wdata;
      end
      if (state == S_RD && !paused && cnt >= 3'd2)
        rbuf[cnt[1:0] - 2'd2] <= mem_din;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency byte RAM model and a write log.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        inst_IF_req = 1'b0;
  logic [31:0] inst_IF_addr = '0;
  logic        inst_IF_flag;
  logic [31:0] inst_IF;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'b00;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_flag;
  logic [31:0] data_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ram [0:1023];
  int          wn = 0;
  logic [31:0] wa = '0;
  logic [7:0]  wd = '0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .inst_IF_req(inst_IF_req), .inst_IF_addr(inst_IF_addr),
    .inst_IF_flag(inst_IF_flag), .inst_IF(inst_IF),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_flag(data_flag), .data_rdata(data_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) begin
      wn <= wn + 1;
      wa <= mem_a;
      wd <= mem_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got_f;
    bit got_d;
    int first;

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[4] = 8'h13; ram[5] = 8'h05; ram[6] = 8'h00; ram[7] = 8'h00;
    ram[0] = 8'h93; ram[1] = 8'h00; ram[2] = 8'h10; ram[3] = 8'h00;
    ram[512] = 8'h34; ram[513] = 8'h12;

    // Reset state
    #12;
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst flags", {30'b0, inst_IF_flag, data_flag}, 32'h0);
    chk("rst inst_IF", inst_IF, 32'h0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Test 1: fetch word at 0x4
    inst_IF_req = 1'b1; inst_IF_addr = 32'h4;
    tick(); chk("t1 a0", mem_a, 32'h4); chk("t1 wr0", {31'b0, mem_wr}, 32'h0);
    tick(); chk("t1 a1", mem_a, 32'h5);
    tick(); chk("t1 a2", mem_a, 32'h6);
    tick(); chk("t1 a3", mem_a, 32'h7);
    tick(); chk("t1 flag early", {31'b0, inst_IF_flag}, 32'h0);
    tick(); chk("t1 flag", {31'b0, inst_IF_flag}, 32'h1); chk("t1 word", inst_IF, 32'h00000513);
    inst_IF_req = 1'b0;
    tick(); chk("t1 flag pulse", {31'b0, inst_IF_flag}, 32'h0);

    // Test 2: store word 0xDEADBEEF at 0x100
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10;
    data_addr = 32'h100; data_wdata = 32'hDEADBEEF;
    tick(); chk("t2 b0", {mem_a[23:0], mem_dout}, 32'h000100EF); chk("t2 wr0", {31'b0, mem_wr}, 32'h1);
    tick(); chk("t2 b1", {mem_a[23:0], mem_dout}, 32'h000101BE); chk("t2 wr1", {31'b0, mem_wr}, 32'h1);
    tick(); chk("t2 b2", {mem_a[23:0], mem_dout}, 32'h000102AD);
    tick(); chk("t2 b3", {mem_a[23:0], mem_dout}, 32'h000103DE); chk("t2 wr3", {31'b0, mem_wr}, 32'h1);
    tick(); chk("t2 flag", {31'b0, data_flag}, 32'h1); chk("t2 wr off", {31'b0, mem_wr}, 32'h0);
    data_req = 1'b0;
    tick(); chk("t2 flag pulse", {31'b0, data_flag}, 32'h0);
    chk("t2 wcount", wn, 32'd4);
    chk("t2 last write", {wa[23:0], wd}, 32'h000103DE);

    // Test 3: IO byte store with UART back-pressure for 3 cycles
    io_buffer_full = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b00;
    data_addr = 32'h00030000; data_wdata = 32'h00000041;
    tick(); chk("t3 stall0", {30'b0, mem_wr, data_flag}, 32'h0);
    tick(); chk("t3 stall1", {30'b0, mem_wr, data_flag}, 32'h0);
    tick(); chk("t3 stall2", {30'b0, mem_wr, data_flag}, 32'h0);
    io_buffer_full = 1'b0;
    tick(); chk("t3 issue", {31'b0, mem_wr}, 32'h1); chk("t3 addr", mem_a, 32'h00030000);
    chk("t3 dout", {24'b0, mem_dout}, 32'h41);
    tick(); chk("t3 flag", {30'b0, mem_wr, data_flag}, 32'h1);
    data_req = 1'b0; data_wr = 1'b0;
    tick(); chk("t3 flag pulse", {31'b0, data_flag}, 32'h0);
    chk("t3 wcount", wn, 32'd5);
    chk("t3 last write", wa, 32'h00030000);

    // Test 4: simultaneous fetch @0 and load half @0x200, then a second tie
    inst_IF_req = 1'b1; inst_IF_addr = 32'h0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b01; data_addr = 32'h200;
    tick(); chk("t4 first grant", mem_a, 32'h200);
    tick(); chk("t4 a1", mem_a, 32'h201);
    tick(); chk("t4 no flag yet", {31'b0, data_flag}, 32'h0);
    tick(); chk("t4 load flag", {30'b0, inst_IF_flag, data_flag}, 32'h1);
    chk("t4 half", data_rdata, 32'h00001234);
    data_req = 1'b0;
    tick(); chk("t4 no grant in flag cycle", mem_a, 32'h201);
    data_req = 1'b1; data_size = 2'b00; data_addr = 32'h201;
    tick();
`ifdef MEM_ARB_RR_EN
    chk("t4 second tie", mem_a, 32'h0);
`else
    chk("t4 second tie", mem_a, 32'h201);
`endif
    got_f = 1'b0; got_d = 1'b0; first = 0;
    for (int c = 0; c < 25 && !(got_f && got_d); c++) begin
      tick();
      if (inst_IF_flag) begin
        if (first == 0) first = 1;
        got_f = 1'b1;
        chk("t4 fetch word", inst_IF, 32'h00100093);
        inst_IF_req = 1'b0;
      end
      if (data_flag) begin
        if (first == 0) first = 2;
        got_d = 1'b1;
        chk("t4 byte load", data_rdata, 32'h00000012);
        data_req = 1'b0;
      end
    end
    chk("t4 fetch done", {31'b0, got_f}, 32'h1);
    chk("t4 load done", {31'b0, got_d}, 32'h1);
`ifdef MEM_ARB_RR_EN
    chk("t4 order", first, 32'd1);
`else
    chk("t4 order", first, 32'd2);
`endif
    inst_IF_req = 1'b0; data_req = 1'b0;
    tick();

    // Test 5: flush after two fetch bytes, then a fresh fetch @0
    inst_IF_req = 1'b1; inst_IF_addr = 32'h4;
    tick(); chk("t5 a0", mem_a, 32'h4);
    tick(); chk("t5 a1", mem_a, 32'h5);
    flush = 1'b1; inst_IF_addr = 32'h0;
    tick(); flush = 1'b0;
    chk("t5 no flag", {31'b0, inst_IF_flag}, 32'h0);
    tick(); chk("t5 refetch", mem_a, 32'h0);
    tick(); chk("t5 no stale flag1", {31'b0, inst_IF_flag}, 32'h0);
    tick(); chk("t5 no stale flag2", {31'b0, inst_IF_flag}, 32'h0);
    tick(); chk("t5 no stale flag3", {31'b0, inst_IF_flag}, 32'h0);
    tick(); chk("t5 no stale flag4", {31'b0, inst_IF_flag}, 32'h0);
    tick(); chk("t5 flag", {31'b0, inst_IF_flag}, 32'h1); chk("t5 word", inst_IF, 32'h00100093);
    inst_IF_req = 1'b0;
    tick();

    // Test 6a: asynchronous reset in the middle of a word read
    inst_IF_req = 1'b1; inst_IF_addr = 32'h4;
    tick(); tick(); tick();
    chk("t6 pre-reset a", mem_a, 32'h6);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst mem_a", mem_a, 32'h0);
    chk("t6 rst dout", {24'b0, mem_dout}, 32'h0);
    chk("t6 rst inst_IF", inst_IF, 32'h0);
    chk("t6 rst data_rdata", data_rdata, 32'h0);
    chk("t6 rst flags wr", {29'b0, inst_IF_flag, data_flag, mem_wr}, 32'h0);
    inst_IF_req = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();

    // Test 6b: rdy low for 3 cycles during a word read
    inst_IF_req = 1'b1; inst_IF_addr = 32'h4;
    tick(); chk("t6 a0", mem_a, 32'h4);
    tick(); tick(); chk("t6 a2", mem_a, 32'h6);
    rdy = 1'b0;
    tick(); tick(); tick();
    chk("t6 hold a", mem_a, 32'h6);
    chk("t6 hold flag", {31'b0, inst_IF_flag}, 32'h0);
    rdy = 1'b1;
    tick(); chk("t6 restart", mem_a, 32'h4);
    tick(); chk("t6 r1", mem_a, 32'h5);
    tick(); chk("t6 r2", mem_a, 32'h6);
    tick(); chk("t6 r3", mem_a, 32'h7);
    tick(); chk("t6 flag early", {31'b0, inst_IF_flag}, 32'h0);
    tick(); chk("t6 flag", {31'b0, inst_IF_flag}, 32'h1); chk("t6 word", inst_IF, 32'h00000513);
    inst_IF_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
